// File: rtl/validador_pecas.sv
// Battleship piece validator: checks a requested piece against one of two
// occupancy bitmaps and stores it when legal. Optional macro: VALIDADOR_ADJ_EN.
module validador_pecas #(
   parameter int BOARD = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valida,
   input  logic [2:0] tipo,
   input  logic       direcao,
   input  logic [2:0] orientacao,
   input  logic [3:0] x1,
   input  logic [3:0] y1,
   input  logic       jogador,
   input  logic [3:0] cons_x,
   input  logic [3:0] cons_y,
   input  logic       cons_jog,
   output logic       conflito,
   output logic       pronto,
   output logic       ocupado,
   output logic [6:0] n_cel0,
   output logic [6:0] n_cel1
);

   localparam logic [5:0] BOARD6 = 6'(BOARD);
   localparam logic [4:0] BOARD5 = 5'(BOARD);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [2:0] r_tipo;
   logic       r_dir;
   logic       r_ori;
   logic [3:0] r_x;
   logic [3:0] r_y;
   logic       r_jog;
   logic [2:0] r_k;
   logic       r_conflito;
   logic       r_pronto;
   logic       r_ocupado;
   logic [6:0] r_n_cel0;
   logic [6:0] r_n_cel1;
   // Full 16x16 storage so any 4-bit address indexes safely; cells >= BOARD stay 0.
   logic [1:0][15:0][15:0] r_map;

   logic [5:0] w_ax;
   logic [5:0] w_ay;
   logic [5:0] w_step;
   logic [5:0] w_cx;
   logic [5:0] w_cy;
   logic       w_off;
   logic       w_hit;
   logic       w_adj;
   logic       w_cell_bad;
   logic       w_last;
   logic       w_illegal;
   logic       w_q_on;
   logic       w_latch;
   logic       w_set_conf;
   logic       w_wr;
   logic       w_k_inc;
   logic       w_k_clr;
   logic       w_unused_ori;

   assign w_unused_ori = ^orientacao[2:1];

   // True when any on-board 4-neighbour of (cx,cy) is occupied in board m.
   function automatic logic adj_occ(input logic [15:0][15:0] m,
                                    input logic [3:0] cx,
                                    input logic [3:0] cy);
      logic occ;
      occ = 1'b0;
      if (cx != 4'd0) occ = occ | m[cy][cx - 4'd1];
      else            occ = occ;
      if (({1'b0, cx} + 5'd1) < BOARD5) occ = occ | m[cy][cx + 4'd1];
      else                              occ = occ;
      if (cy != 4'd0) occ = occ | m[cy - 4'd1][cx];
      else            occ = occ;
      if (({1'b0, cy} + 5'd1) < BOARD5) occ = occ | m[cy + 4'd1][cx];
      else                              occ = occ;
      return occ;
   endfunction

   assign w_ax      = {2'b00, r_x};
   assign w_ay      = {2'b00, r_y};
   assign w_step    = {3'b000, r_k};
   assign w_last    = (r_k == r_tipo);
   assign w_illegal = (tipo > 3'd4);
   assign w_q_on    = ({1'b0, cons_x} < BOARD5) && ({1'b0, cons_y} < BOARD5);

   // Candidate cell k; 6-bit math makes an underflow land far above BOARD.
   always_comb begin
      w_cx = w_ax;
      w_cy = w_ay;
      if (r_dir == 1'b0) begin
         if (r_ori) w_cx = w_ax - w_step;
         else       w_cx = w_ax + w_step;
      end else begin
         if (r_ori) w_cy = w_ay - w_step;
         else       w_cy = w_ay + w_step;
      end
   end

   assign w_off = (w_cx >= BOARD6) || (w_cy >= BOARD6);
   assign w_hit = r_map[r_jog][w_cy[3:0]][w_cx[3:0]];
`ifdef VALIDADOR_ADJ_EN
   assign w_adj = adj_occ(r_map[r_jog], w_cx[3:0], w_cy[3:0]);
`else
   assign w_adj = 1'b0;
`endif
   assign w_cell_bad = w_off | w_hit | w_adj;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and datapath control strobes.
   always_comb begin
      w_next     = r_state;
      w_latch    = 1'b0;
      w_set_conf = 1'b0;
      w_wr       = 1'b0;
      w_k_inc    = 1'b0;
      w_k_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valida) begin
               w_latch = 1'b1;
               if (w_illegal) w_next = S_DONE;
               else           w_next = S_CHECK;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_CHECK: begin
            if (w_cell_bad) begin
               w_set_conf = 1'b1;
               w_next     = S_DONE;
            end else if (w_last) begin
               w_k_clr = 1'b1;
               w_next  = S_WRITE;
            end else begin
               w_k_inc = 1'b1;
            end
         end
         S_WRITE: begin
            w_wr = 1'b1;
            if (w_last) w_next = S_DONE;
            else        w_k_inc = 1'b1;
         end
         S_DONE:  w_next = S_WAIT;
         S_WAIT: begin
            if (!valida) w_next = S_IDLE;
            else         w_next = S_WAIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Request latch, cell index, result flags, bitmaps, counters and query port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tipo     <= 3'd0;
         r_dir      <= 1'b0;
         r_ori      <= 1'b0;
         r_x        <= 4'd0;
         r_y        <= 4'd0;
         r_jog      <= 1'b0;
         r_k        <= 3'd0;
         r_conflito <= 1'b0;
         r_pronto   <= 1'b0;
         r_ocupado  <= 1'b0;
         r_n_cel0   <= 7'd0;
         r_n_cel1   <= 7'd0;
         r_map      <= '0;
      end else begin
         r_pronto  <= (r_state == S_DONE);
         r_ocupado <= w_q_on ? r_map[cons_jog][cons_y][cons_x] : 1'b0;
         if (w_latch) begin
            r_tipo     <= tipo;
            r_dir      <= direcao;
            r_ori      <= orientacao[0];
            r_x        <= x1;
            r_y        <= y1;
            r_jog      <= jogador;
            r_k        <= 3'd0;
            r_conflito <= w_illegal;
         end else if (w_set_conf) begin
            r_conflito <= 1'b1;
         end else if (w_k_clr) begin
            r_k <= 3'd0;
         end else if (w_k_inc) begin
            r_k <= r_k + 3'd1;
         end else begin
            r_k <= r_k;
         end
         if (w_wr) begin
            r_map[r_jog][w_cy[3:0]][w_cx[3:0]] <= 1'b1;
            if (r_jog) r_n_cel1 <= r_n_cel1 + 7'd1;
            else       r_n_cel0 <= r_n_cel0 + 7'd1;
         end else begin
            r_n_cel0 <= r_n_cel0;
         end
      end
   end

   assign conflito = r_conflito;
   assign pronto   = r_pronto;
   assign ocupado  = r_ocupado;
   assign n_cel0   = r_n_cel0;
   assign n_cel1   = r_n_cel1;

endmodule
